food_spawner: RTL and testbench
===============================

// Module: food_spawner
// PURPOSE
//  Parametrised food generator for the snake game.
//  Places food on a GRID_W x GRID_H board, only ever on a cell the snake does not occupy.
//  Detects when the head eats the food, keeps a saturating score and respawns the food.
//  Sits between the snake body/occupancy logic and the display/score path.
// PARAMETERS
//  GRID_W     8        board columns (2..64)
//  GRID_H     8        board rows (2..64)
//  XW         $clog2(GRID_W)  x coordinate width
//  YW         $clog2(GRID_H)  y coordinate width
//  LFSR_SEED  16'hACE1 LFSR reset value (nonzero)
//  MAX_TRIES  16       random rejections before falling back to a linear scan
//  SCORE_W    8        score width
// PORTS
//  clk_food    in   1               game clock
//  reset       in   1               asynchronous, active-low reset
//  head_x      in   XW              snake head column
//  head_y      in   YW              snake head row
//  occupancy   in   GRID_W*GRID_H   1 = cell occupied; bit index y*GRID_W+x
//  food_x      out  XW              current food column
//  food_y      out  YW              current food row
//  food_valid  out  1               food is placed and displayable
//  eaten       out  1               1-cycle pulse: head reached food
//  food_lost   out  1               1-cycle pulse: body covered food without the head
//  grid_full   out  1               no free cell exists; sticky until reset
//  score       out  SCORE_W         number of foods eaten, saturating
// BEHAVIOUR
//  Reset (reset=0, async): state=SEARCH, lfsr=LFSR_SEED, tries=0, scan ptr=0.
//    All outputs are 0 during and after reset.
//  LFSR: 16-bit Galois (taps 16,14,13,11); advances every cycle in every state.
//    cand_x = lfsr[XW-1:0], cand_y = lfsr[8+YW-1:8].
//  SEARCH, evaluated once per cycle:
//    Reject if cand_x>=GRID_W or cand_y>=GRID_H. No modulo, so the distribution is unbiased.
//    Reject if the occupancy bit is 1.
//    Reject if the candidate equals (head_x,head_y).
//    On accept: register food_x/y, set food_valid=1 next cycle, go HOLD, tries=0.
//    On reject: tries++. When tries==MAX_TRIES-1 and the cycle rejects: go SCAN, ptr=0.
//  SCAN: ptr walks row-major, one cell per cycle. A cell is eligible when it is free and is not the head.
//    First eligible cell: latch it, go HOLD.
//    If ptr reaches GRID_W*GRID_H-1 with no eligible cell: go FULL.
//  HOLD: food_valid=1. The compare uses current inputs; outputs are registered.
//    head==food: eaten=1 for one cycle; score+=1, saturating at all-ones.
//      food_valid drops to 0 on the same edge; go SEARCH.
//    Otherwise, if occupancy[food]=1: food_lost=1 for one cycle; score unchanged;
//      food_valid drops to 0; go SEARCH.
//    If head==food and occupancy[food]=1 in the same cycle: eaten wins; food_lost stays 0.
//  FULL: grid_full=1, food_valid=0; leaves FULL only on reset.
//  Latency:
//    - reset release to first food_valid: >=1 cycle (SEARCH accept).
//    - eat to new food_valid: >=2 cycles.
//    - worst case: MAX_TRIES + GRID_W*GRID_H + 1 cycles.
//  Inputs head_*/occupancy are synchronous to clk_food; they are not resynchronised.
//  Reset asserted mid-SEARCH/SCAN aborts the search immediately; no partial coordinates escape.
//  Single-cycle pulses never stretch; back-to-back eats are impossible, since HOLD is required first.
// STRUCTURE
//  food_pkg: state enum {SEARCH,SCAN,HOLD,FULL}; LFSR tap mask; default LFSR seed.
//  Sub-module food_lfsr: 16-bit Galois LFSR with async active-low reset to SEED.
//    Output is the 16-bit state.
//  Top level holds the FSM, tries/ptr counters, cell-index mux, and score register.
// TESTING
//  1 Empty board, default seed, release reset:
//    food_valid=1 within 2 cycles.
//    The food cell has occupancy 0, lies inside the grid, and is not the head.
//  2 Food at (3,5); drive head to (3,5):
//    eaten pulses exactly 1 cycle; score 0->1; food_valid drops.
//    New food appears at a different free cell.
//  3 Occupancy all-ones except cell (7,7); head elsewhere:
//    MAX_TRIES rejects, then SCAN.
//    Food lands at (7,7) within MAX_TRIES+64+2 cycles.
//  4 Occupancy all-ones:
//    grid_full=1 after the scan completes; food_valid stays 0; reset clears grid_full.
//  5 In HOLD, set occupancy[food]=1 with head elsewhere:
//    food_lost pulse, score unchanged, respawn.
//    Repeat with head==food on the same cycle: eaten only.
//  6 Force score to 255 with SCORE_W=8, then eat: score stays 255.
//    Assert reset mid-SCAN: all outputs read 0 asynchronously.
//  Regress with GRID_W=12, GRID_H=5 to exercise the non-power-of-2 reject path.

Source files
------------

// File: rtl/food_pkg.sv
// Shared types and constants for the snake-game food spawner.
// Holds the FSM state encoding, the LFSR polynomial and its default seed.
package food_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    SCAN   = 2'd1,
    HOLD   = 2'd2,
    FULL   = 2'd3
  } state_t;

  // Galois form of x^16 + x^14 + x^13 + x^11 + 1, shifting right.
  localparam logic [15:0] LFSR_TAPS         = 16'hB400;
  localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/food_lfsr.sv
// Free-running 16-bit Galois LFSR used as the food candidate source.
// Advances every cycle; reset loads SEED, which must be nonzero.
module food_lfsr
  import food_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_SEED_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] state
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SEED;
    end else begin
      state <= lfsr_next(state);
    end
  end

endmodule

// File: rtl/food_spawner.sv
// Food placement, eat/loss detection and saturating score for the snake game.
// Random placement with rejection sampling, falling back to a row-major scan.
module food_spawner
  import food_pkg::*;
#(
  parameter int          GRID_W    = 8,
  parameter int          GRID_H    = 8,
  parameter int          XW        = $clog2(GRID_W),
  parameter int          YW        = $clog2(GRID_H),
  parameter logic [15:0] LFSR_SEED = LFSR_SEED_DEFAULT,
  parameter int          MAX_TRIES = 16,
  parameter int          SCORE_W   = 8
) (
  input  logic                     clk_food,
  input  logic                     reset,
  input  logic [XW-1:0]            head_x,
  input  logic [YW-1:0]            head_y,
  input  logic [GRID_W*GRID_H-1:0] occupancy,
  output logic [XW-1:0]            food_x,
  output logic [YW-1:0]            food_y,
  output logic                     food_valid,
  output logic                     eaten,
  output logic                     food_lost,
  output logic                     grid_full,
  output logic [SCORE_W-1:0]       score
);

  localparam int              IW       = XW + YW;
  localparam int              TW       = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam logic [XW:0]     GW_L     = (XW+1)'(GRID_W);
  localparam logic [YW:0]     GH_L     = (YW+1)'(GRID_H);
  localparam logic [XW-1:0]   X_LAST   = XW'(GRID_W - 1);
  localparam logic [YW-1:0]   Y_LAST   = YW'(GRID_H - 1);
  localparam logic [TW-1:0]   TRY_LAST = TW'(MAX_TRIES - 1);
  localparam logic [IW-1:0]   GW_I     = IW'(GRID_W);

  // Row-major cell index; IW bits always cover y*GRID_W+x for any in-range coordinate.
  function automatic logic [IW-1:0] cell_of(input logic [XW-1:0] x, input logic [YW-1:0] y);
    return IW'(y) * GW_I + IW'(x);
  endfunction

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    return (&s) ? s : s + SCORE_W'(1);
  endfunction

  logic [15:0]          lfsr;
  logic                 lfsr_unused;
  state_t               state, state_nxt;
  logic [TW-1:0]        tries, tries_nxt;
  logic [XW-1:0]        scan_x, scan_x_nxt;
  logic [YW-1:0]        scan_y, scan_y_nxt;
  logic [XW-1:0]        food_x_nxt;
  logic [YW-1:0]        food_y_nxt;
  logic                 food_valid_nxt, eaten_nxt, food_lost_nxt, grid_full_nxt;
  logic [SCORE_W-1:0]   score_nxt;
  logic [2**IW-1:0]     occ_pad;

  logic [XW-1:0]        sel_x_p0;
  logic [YW-1:0]        sel_y_p0;
  logic                 in_grid_p0, is_head_p0, free_p0;
  logic                 food_head_p0, food_occ_p0;

  food_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk_food),
    .rst_n (reset),
    .state (lfsr)
  );

  assign lfsr_unused = ^{lfsr[15:8+YW], lfsr[7:XW]};

  // Padding lets any IW-bit index address the occupancy map without a range check.
  assign occ_pad = (2**IW)'(occupancy);

  // ---- p0: evaluate the candidate cell (random or scan pointer) against the board
  assign sel_x_p0     = (state == SCAN) ? scan_x : lfsr[XW-1:0];
  assign sel_y_p0     = (state == SCAN) ? scan_y : lfsr[8+YW-1:8];
  assign in_grid_p0   = ({1'b0, sel_x_p0} < GW_L) && ({1'b0, sel_y_p0} < GH_L);
  assign is_head_p0   = (sel_x_p0 == head_x) && (sel_y_p0 == head_y);
  assign free_p0      = in_grid_p0 && !occ_pad[cell_of(sel_x_p0, sel_y_p0)] && !is_head_p0;
  assign food_head_p0 = (food_x == head_x) && (food_y == head_y);
  assign food_occ_p0  = occ_pad[cell_of(food_x, food_y)];

  always_comb begin
    state_nxt      = state;
    tries_nxt      = tries;
    scan_x_nxt     = scan_x;
    scan_y_nxt     = scan_y;
    food_x_nxt     = food_x;
    food_y_nxt     = food_y;
    food_valid_nxt = food_valid;
    eaten_nxt      = 1'b0;
    food_lost_nxt  = 1'b0;
    grid_full_nxt  = grid_full;
    score_nxt      = score;
    case (state)
      SEARCH: begin
        if (free_p0) begin
          food_x_nxt     = sel_x_p0;
          food_y_nxt     = sel_y_p0;
          food_valid_nxt = 1'b1;
          tries_nxt      = '0;
          state_nxt      = HOLD;
        end else if (tries == TRY_LAST) begin
          // Clearing tries here gives the next search its full random budget.
          tries_nxt  = '0;
          scan_x_nxt = '0;
          scan_y_nxt = '0;
          state_nxt  = SCAN;
        end else begin
          tries_nxt = tries + TW'(1);
        end
      end
      SCAN: begin
        if (free_p0) begin
          food_x_nxt     = sel_x_p0;
          food_y_nxt     = sel_y_p0;
          food_valid_nxt = 1'b1;
          state_nxt      = HOLD;
        end else if ((scan_x == X_LAST) && (scan_y == Y_LAST)) begin
          grid_full_nxt  = 1'b1;
          food_valid_nxt = 1'b0;
          state_nxt      = FULL;
        end else if (scan_x == X_LAST) begin
          scan_x_nxt = '0;
          scan_y_nxt = scan_y + YW'(1);
        end else begin
          scan_x_nxt = scan_x + XW'(1);
        end
      end
      HOLD: begin
        // Head arrival takes priority over the body covering the food.
        if (food_head_p0) begin
          eaten_nxt      = 1'b1;
          score_nxt      = sat_inc(score);
          food_valid_nxt = 1'b0;
          state_nxt      = SEARCH;
        end else if (food_occ_p0) begin
          food_lost_nxt  = 1'b1;
          food_valid_nxt = 1'b0;
          state_nxt      = SEARCH;
        end
      end
      FULL: begin
        grid_full_nxt  = 1'b1;
        food_valid_nxt = 1'b0;
      end
      default: begin
        state_nxt = SEARCH;
      end
    endcase
  end

  // ---- p1: registered state and outputs
  always_ff @(posedge clk_food or negedge reset) begin
    if (!reset) begin
      state      <= SEARCH;
      tries      <= '0;
      scan_x     <= '0;
      scan_y     <= '0;
      food_x     <= '0;
      food_y     <= '0;
      food_valid <= 1'b0;
      eaten      <= 1'b0;
      food_lost  <= 1'b0;
      grid_full  <= 1'b0;
      score      <= '0;
    end else begin
      state      <= state_nxt;
      tries      <= tries_nxt;
      scan_x     <= scan_x_nxt;
      scan_y     <= scan_y_nxt;
      food_x     <= food_x_nxt;
      food_y     <= food_y_nxt;
      food_valid <= food_valid_nxt;
      eaten      <= eaten_nxt;
      food_lost  <= food_lost_nxt;
      grid_full  <= grid_full_nxt;
      score      <= score_nxt;
    end
  end

endmodule

// File: tb/tb_food_spawner.sv
// Scoreboard bench for food_spawner: an 8x8 instance under directed stimulus and a
// 12x5 instance whose head chases the food, both checked against a reference model.
module tb_food_spawner;

  localparam int MAX_TRIES = 16;
  localparam int EV_NONE = 0, EV_PLACE = 1, EV_EAT = 2, EV_LOST = 3, EV_FULL = 4;
  localparam int M_SEARCH = 0, M_SCAN = 1, M_HOLD = 2, M_FULL = 3;

  typedef struct {
    int          st;
    logic [15:0] lfsr;
    int          tries;
    int          ptr;
    int          fx;
    int          fy;
    bit          fv;
    bit          full;
    int          score;
  } mdl_t;

  typedef struct {
    int kind;
    int x;
    int y;
    int score;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  head_x, head_y;
  logic [63:0] occ;
  logic [2:0]  food_x, food_y;
  logic        food_valid, eaten, food_lost, grid_full;
  logic [7:0]  score;

  logic [3:0]  head2_x, food2_x;
  logic [2:0]  head2_y, food2_y;
  logic [59:0] occ2;
  logic        food_valid2, eaten2, food_lost2, grid_full2;
  logic [7:0]  score2;

  int   errors = 0;
  int   checks = 0;
  int   exp_sc;
  mdl_t m0, m1;
  ev_t  q0[$];
  ev_t  q1[$];
  bit   pfv0, pfull0, pfv1, pfull1;

  always #5 clk = ~clk;

  food_spawner u_dut (
    .clk_food   (clk),
    .reset      (rst_n),
    .head_x     (head_x),
    .head_y     (head_y),
    .occupancy  (occ),
    .food_x     (food_x),
    .food_y     (food_y),
    .food_valid (food_valid),
    .eaten      (eaten),
    .food_lost  (food_lost),
    .grid_full  (grid_full),
    .score      (score)
  );

  food_spawner #(.GRID_W(12), .GRID_H(5)) u_dut2 (
    .clk_food   (clk),
    .reset      (rst_n),
    .head_x     (head2_x),
    .head_y     (head2_y),
    .occupancy  (occ2),
    .food_x     (food2_x),
    .food_y     (food2_y),
    .food_valid (food_valid2),
    .eaten      (eaten2),
    .food_lost  (food_lost2),
    .grid_full  (grid_full2),
    .score      (score2)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void mreset(output mdl_t m);
    m.st = M_SEARCH; m.lfsr = 16'hACE1; m.tries = 0; m.ptr = 0;
    m.fx = 0; m.fy = 0; m.fv = 0; m.full = 0; m.score = 0;
  endfunction

  // One clock of the reference behaviour; returns the output event it produces.
  function automatic int mstep(inout mdl_t m, input int gw, input int gh, input int xw,
                               input int yw, input int hx, input int hy, input logic [63:0] o);
    int ev = EV_NONE;
    int cx, cy;
    bit ok;
    logic [15:0] l = m.lfsr;
    case (m.st)
      M_SEARCH: begin
        cx = int'(l) % (1 << xw);
        cy = (int'(l) >> 8) % (1 << yw);
        ok = (cx < gw) && (cy < gh);
        if (ok) ok = !o[6'(cy * gw + cx)] && !(cx == hx && cy == hy);
        if (ok) begin
          m.fx = cx; m.fy = cy; m.fv = 1; m.tries = 0; m.st = M_HOLD; ev = EV_PLACE;
        end else if (m.tries == MAX_TRIES - 1) begin
          m.tries = 0; m.ptr = 0; m.st = M_SCAN;
        end else begin
          m.tries++;
        end
      end
      M_SCAN: begin
        cx = m.ptr % gw;
        cy = m.ptr / gw;
        if (!o[6'(m.ptr)] && !(cx == hx && cy == hy)) begin
          m.fx = cx; m.fy = cy; m.fv = 1; m.st = M_HOLD; ev = EV_PLACE;
        end else if (m.ptr == gw * gh - 1) begin
          m.full = 1; m.st = M_FULL; ev = EV_FULL;
        end else begin
          m.ptr++;
        end
      end
      M_HOLD: begin
        if (m.fx == hx && m.fy == hy) begin
          m.score = (m.score < 255) ? m.score + 1 : 255;
          m.fv = 0; m.st = M_SEARCH; ev = EV_EAT;
        end else if (o[6'(m.fy * gw + m.fx)]) begin
          m.fv = 0; m.st = M_SEARCH; ev = EV_LOST;
        end
      end
      default: ;
    endcase
    m.lfsr = (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
    return ev;
  endfunction

  // Reference model: predicts events and queues them for the monitor.
  initial begin
    int ev;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mreset(m0); mreset(m1);
        q0.delete(); q1.delete();
      end else begin
        ev = mstep(m0, 8, 8, 3, 3, int'(head_x), int'(head_y), occ);
        if (ev != EV_NONE) q0.push_back('{ev, m0.fx, m0.fy, m0.score});
        ev = mstep(m1, 12, 5, 4, 3, int'(head2_x), int'(head2_y), {4'b0, occ2});
        if (ev != EV_NONE) q1.push_back('{ev, m1.fx, m1.fy, m1.score});
      end
    end
  end

  task automatic mon(input int k, input bit fv, input bit pfv, input bit eat, input bit lost,
                     input bit full, input bit pfull, input int fx, input int fy, input int sc,
                     input mdl_t m);
    int  dk;
    ev_t e;
    bit  have;
    dk = EV_NONE;
    if (fv && !pfv) dk = EV_PLACE;
    else if (eat) dk = EV_EAT;
    else if (lost) dk = EV_LOST;
    else if (full && !pfull) dk = EV_FULL;
    have = 0;
    e = '{EV_NONE, 0, 0, 0};
    if (k == 0) begin
      if (q0.size() > 0) begin e = q0.pop_front(); have = 1; end
    end else begin
      if (q1.size() > 0) begin e = q1.pop_front(); have = 1; end
    end
    if (have || dk != EV_NONE) begin
      chk($sformatf("d%0d_event_kind", k), dk, e.kind);
      if (have && dk == e.kind) begin
        if (e.kind == EV_PLACE) begin
          chk($sformatf("d%0d_place_x", k), fx, e.x);
          chk($sformatf("d%0d_place_y", k), fy, e.y);
        end else if (e.kind == EV_EAT || e.kind == EV_LOST) begin
          chk($sformatf("d%0d_event_score", k), sc, e.score);
        end
      end
    end
    chk($sformatf("d%0d_food_valid", k), fv, m.fv);
    chk($sformatf("d%0d_grid_full", k), full, m.full);
    chk($sformatf("d%0d_score", k), sc, m.score);
    chk($sformatf("d%0d_pulse_excl", k), eat & lost, 0);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        mon(0, food_valid, pfv0, eaten, food_lost, grid_full, pfull0,
            int'(food_x), int'(food_y), int'(score), m0);
        mon(1, food_valid2, pfv1, eaten2, food_lost2, grid_full2, pfull1,
            int'(food2_x), int'(food2_y), int'(score2), m1);
      end
      pfv0 = food_valid; pfull0 = grid_full;
      pfv1 = food_valid2; pfull1 = grid_full2;
    end
  end

  // The 12x5 head steps onto every food as soon as it appears.
  initial begin
    head2_x = '0;
    head2_y = '0;
    for (int i = 0; i < 60; i++) occ2[i] = (((i % 12) + (i / 12)) % 3 == 0);
    forever begin
      @(negedge clk);
      if (food_valid2) begin
        head2_x = food2_x;
        head2_y = food2_y;
      end
    end
  end

  task automatic wait_fv(input string nm, input int budget);
    int n = 0;
    while (!food_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(nm, food_valid, 1);
  endtask

  task automatic eat_food(input int exp_score);
    wait_fv("eat_wait_food", 100);
    head_x = food_x;
    head_y = food_y;
    @(negedge clk);
    chk("eat_pulse", eaten, 1);
    chk("eat_valid_drop", food_valid, 0);
    chk("eat_score", score, exp_score);
    @(negedge clk);
    chk("eat_pulse_single", eaten, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ox, oy, n;
    rst_n  = 1'b0;
    head_x = '0;
    head_y = '0;
    occ    = '0;
    repeat (3) @(negedge clk);
    chk("rst_food_valid", food_valid, 0);
    chk("rst_score", score, 0);
    chk("rst_grid_full", grid_full, 0);
    chk("rst_food_xy", {food_x, food_y}, 0);
    rst_n = 1'b1;

    // Empty board: seed 0xACE1 gives candidate (1,4) on the first cycle.
    @(negedge clk);
    chk("first_food_valid", food_valid, 1);
    chk("first_food_x", food_x, 1);
    chk("first_food_y", food_y, 4);

    // Eat it; the replacement must land elsewhere.
    ox = int'(food_x);
    oy = int'(food_y);
    eat_food(1);
    wait_fv("respawn_wait", 100);
    chk("respawn_differs", (int'(food_x) == ox && int'(food_y) == oy), 0);

    // Only (7,7) free: random tries fail, the scan finds it.
    occ = '1;
    occ[63] = 1'b0;
    @(negedge clk);
    n = 0;
    while (!(food_valid && food_x == 3'd7 && food_y == 3'd7) && n < MAX_TRIES + 64 + 4) begin
      @(negedge clk);
      n++;
    end
    chk("scan_food_x", food_x, 7);
    chk("scan_food_y", food_y, 7);

    // Body covers the food with the head elsewhere.
    occ[63] = 1'b1;
    @(negedge clk);
    chk("lost_pulse", food_lost, 1);
    chk("lost_no_eat", eaten, 0);
    chk("lost_valid_drop", food_valid, 0);
    chk("lost_score_kept", score, 1);
    @(negedge clk);
    chk("lost_pulse_single", food_lost, 0);

    // Completely full board.
    n = 0;
    while (!grid_full && n < MAX_TRIES + 64 + 4) begin
      @(negedge clk);
      n++;
    end
    chk("full_set", grid_full, 1);
    chk("full_no_food", food_valid, 0);
    repeat (5) @(negedge clk);
    chk("full_sticky", grid_full, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("full_cleared_by_reset", grid_full, 0);
    occ    = '0;
    head_x = '0;
    head_y = '0;
    rst_n  = 1'b1;

    // Head arrives and body covers the food on the same cycle: eat wins.
    wait_fv("tie_wait_food", 100);
    head_x = food_x;
    head_y = food_y;
    occ[6'(int'(food_y) * 8 + int'(food_x))] = 1'b1;
    @(negedge clk);
    chk("tie_eaten", eaten, 1);
    chk("tie_not_lost", food_lost, 0);
    chk("tie_score", score, 1);
    occ = '0;
    exp_sc = 1;

    // Drive the score into saturation.
    for (int i = 0; i < 256; i++) begin
      exp_sc = (exp_sc < 255) ? exp_sc + 1 : 255;
      eat_food(exp_sc);
    end
    chk("score_saturated", score, 255);

    // Abort mid-scan with an asynchronous reset.
    occ = '1;
    repeat (30) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_score", score, 0);
    chk("async_rst_valid", food_valid, 0);
    chk("async_rst_full", grid_full, 0);
    chk("async_rst_pulses", {eaten, food_lost}, 0);
    chk("async_rst_food_xy", {food_x, food_y}, 0);
    repeat (2) @(negedge clk);
    occ   = '0;
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
